// File: rtl/key_pkg.sv
// Shared definitions for the key debounce array.
//   rpt_state_e : per-channel auto-repeat FSM state encoding
//   clog2       : bit width needed to hold values 0..value-1
//   max2        : larger of two values, used to size the shared repeat timer
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } rpt_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned w;
        v = (value > 0) ? value - 1 : 0;
        w = 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return w;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_array_if.sv
// Key/event bundle between the debounce array and its environment.
//   key_in, repeat_en             : raw keys and auto-repeat enable (into the array)
//   key_level/press/release/repeat: per-key conditioned outputs
//   evt_valid/evt_code/evt_multi  : merged, prioritised key-event stream
// Modports: slave = the debounce array, master = the driving/consuming side.
interface key_debounce_array_if #(
    parameter int unsigned N_KEYS = 3
);
    localparam int unsigned CODE_W = key_pkg::clog2(N_KEYS);

    logic [N_KEYS-1:0] key_in;
    logic              repeat_en;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_repeat;
    logic              evt_valid;
    logic [CODE_W-1:0] evt_code;
    logic              evt_multi;

    modport master (
        output key_in, repeat_en,
        input  key_level, key_press, key_release, key_repeat,
        input  evt_valid, evt_code, evt_multi
    );

    modport slave (
        input  key_in, repeat_en,
        output key_level, key_press, key_release, key_repeat,
        output evt_valid, evt_code, evt_multi
    );

endinterface

// File: rtl/key_debounce_channel.sv
// One key channel: 2-FF synchroniser, counter debounce, registered
// press/release pulses and hold-to-auto-repeat FSM.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   key_i         : raw asynchronous key level
//   repeat_en_i   : auto-repeat enable
//   level_o       : debounced level
//   press_o       : 1-cycle pulse on accepted 0->1
//   release_o     : 1-cycle pulse on accepted 1->0
//   repeat_o      : 1-cycle auto-repeat pulse
module key_debounce_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned REPEAT_CYCLES   = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMR_W = clog2(max2(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] RPT_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    rpt_state_e       state_q, state_d;

    // Debounce: a run of DEBOUNCE_CYCLES differing samples flips the level.
    always_comb begin
        level_d   = level_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d   = s2_q;
                press_d   = s2_q;
                release_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Repeat FSM reacts to the accept decision of the same edge so that the
    // hold timer starts in the press cycle and a coincident release wins.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        repeat_d = 1'b0;
        if (release_d || !repeat_en_i) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press_d) begin
                        state_d = ST_HOLD;
                        tmr_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (tmr_q == HOLD_LAST) begin
                        repeat_d = 1'b1;
                        state_d  = ST_RPT;
                        tmr_d    = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                ST_RPT: begin
                    if (tmr_q == RPT_LAST) begin
                        repeat_d = 1'b1;
                        tmr_d    = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= key_i;
            s2_q      <= s1_q;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            repeat_q <= repeat_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_array.sv
// N-channel push-button conditioner with a merged key-event stream.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   kb (slave)         : raw keys/repeat enable in; per-key levels and
//                        pulses plus prioritised event (valid/code/multi) out
// The lowest-index channel with a press or repeat wins; other simultaneous
// events are flagged by evt_multi and dropped.
module key_debounce_array
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned REPEAT_CYCLES   = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    key_debounce_array_if.slave  kb
);

    localparam int unsigned CODE_W = clog2(N_KEYS);

    logic [N_KEYS-1:0] level_w, press_w, release_w, repeat_w;
    logic [N_KEYS-1:0] src;
    logic              found;
    logic              evt_valid_q, evt_valid_d;
    logic              evt_multi_q, evt_multi_d;
    logic [CODE_W-1:0] evt_code_q, evt_code_d;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk_i       (sys_clk),
            .rst_ni      (sys_rst_n),
            .key_i       (kb.key_in[g]),
            .repeat_en_i (kb.repeat_en),
            .level_o     (level_w[g]),
            .press_o     (press_w[g]),
            .release_o   (release_w[g]),
            .repeat_o    (repeat_w[g])
        );
    end

    assign src = press_w | repeat_w;

    // Priority encoder: first set bit wins, any further set bit marks multi.
    always_comb begin
        found       = 1'b0;
        evt_code_d  = evt_code_q;
        evt_multi_d = 1'b0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (src[i]) begin
                if (!found) begin
                    evt_code_d = CODE_W'(i);
                    found      = 1'b1;
                end else begin
                    evt_multi_d = 1'b1;
                end
            end
        end
        evt_valid_d = found;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            evt_valid_q <= 1'b0;
            evt_multi_q <= 1'b0;
            evt_code_q  <= '0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_multi_q <= evt_multi_d;
            evt_code_q  <= evt_code_d;
        end
    end

    assign kb.key_level   = level_w;
    assign kb.key_press   = press_w;
    assign kb.key_release = release_w;
    assign kb.key_repeat  = repeat_w;
    assign kb.evt_valid   = evt_valid_q;
    assign kb.evt_code    = evt_code_q;
    assign kb.evt_multi   = evt_multi_q;

endmodule
